pic_fetch_unit: RTL
===================

Name: pic_fetch_unit

Overview:
- Instruction fetch stage for the 14-bit-instruction core; reader side of the 2K-word program ROM.
- Drives the 11-bit ROM address and registers the returned 14-bit word into the instruction register (IR), which feeds execute.
- Owns the program counter (PC) and an 8-level hardware return stack.
- Applies PC-control commands from execute: jump, call, return, skip, stall, with pipeline flush.

Parameters:
- ADDR_W, 11, program address width (2K words)
- INSTR_W, 14, instruction width
- STACK_DEPTH, 8, return stack entries (power of 2)
- NOP_WORD, 14'h0000, word inserted into IR on flush/skip

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- rom_addr_out  output  ADDR_W  address to program ROM; equals PC combinationally
- rom_data_in  input  INSTR_W  ROM read data; combinational ROM, valid same cycle as address
- pc_op  input  3  command from execute: 0 NEXT, 1 JUMP, 2 CALL, 3 RETURN, 4 SKIP; 5-7 treated as NEXT
- target  input  ADDR_W  jump/call destination, sampled when pc_op is JUMP or CALL
- stall  input  1  hold all fetch state this cycle
- ir_out  output  INSTR_W  instruction register to execute
- ir_valid  output  1  ir_out holds a real fetched instruction (0 = bubble)
- pc_out  output  ADDR_W  current PC, for debug and PCL reads
- stack_overflow  output  1  sticky; push while the stack is full
- stack_underflow  output  1  sticky; pop while the stack is empty

Behaviour:
- Reset (synchronous, dominates everything):
  - PC=0, IR=NOP_WORD, ir_valid=0.
  - Stack pointer=0, entry count=0, both sticky flags=0.
  - Stack contents are don't-care.
- Pipeline:
  - Two-stage: fetch and execute.
  - PC always points one word past the instruction in IR.
  - Fetch latency is 1 cycle: word at address A appears on ir_out the cycle after rom_addr_out=A.
- Priority each cycle: reset > stall > pc_op.
- stall=1: PC, IR, ir_valid, stack and flags all hold. pc_op is ignored.
- NEXT: IR<=rom_data_in, ir_valid<=1, PC<=PC+1.
- JUMP: PC<=target, IR<=NOP_WORD, ir_valid<=0. One bubble cycle.
- CALL: push current PC (return address = call+1), then PC<=target, IR<=NOP_WORD, ir_valid<=0.
- RETURN: PC<=top of stack, pop, IR<=NOP_WORD, ir_valid<=0.
- SKIP: IR<=NOP_WORD, ir_valid<=0, PC<=PC+1. The word fetched this cycle is discarded.
- PC arithmetic: modulo 2^ADDR_W. 0x7FF+1 wraps to 0x000, no flag.
- Stack:
  - Circular buffer with pointer sp. Push writes entry[sp], then sp<=sp+1. Pop does sp<=sp-1, then reads entry[sp-1]. Pointer wraps mod STACK_DEPTH.
  - Count saturates at 0 and STACK_DEPTH.
  - Push at count=STACK_DEPTH: writes anyway, overwriting the oldest entry, and sets stack_overflow.
  - Pop at count=0: still returns the wrapped entry and sets stack_underflow.
  - Sticky flags clear only on reset.
- Back-to-back commands: any sequence is legal, including RETURN immediately after CALL (returns to call+1).
- Reset asserted mid-call or mid-stall: state is fully re-initialised on the next edge. The fetch after reset is from address 0.
- ir_out and ir_valid are registered outputs. rom_addr_out and pc_out are the PC register itself, with no combinational path from pc_op.

Test Plan:
- Reset then NEXT for 4 cycles, ROM[0..3]=01A1,01A2,303C,00A3:
  - rom_addr_out steps 0,1,2,3,4.
  - ir_out shows 01A1 then 01A2, 303C, 00A3 on consecutive cycles; ir_valid=1 from the first post-reset edge.
- JUMP with target=0x010 while PC=0x009:
  - Next cycle: PC=0x010, ir_valid=0, ir_out=0000.
  - Following cycle: ir_out=ROM[0x010]=0008, ir_valid=1.
- CALL target=0x011 at PC=0x00E, then RETURN:
  - PC goes to 0x011; after RETURN, PC=0x00E.
  - One bubble after each command; no flags set.
- SKIP at PC=0x00C:
  - ROM[0x00C] never reaches ir_out; ir_valid=0 for one cycle.
  - Next valid IR is ROM[0x00D]; PC continues 0x00D, 0x00E.
- Nine nested CALLs then nine RETURNs:
  - stack_overflow=1 after the 9th call; the 9th RETURN gets the wrapped entry and sets stack_underflow=1.
  - Both flags stay set until reset.
- Boundary and control timing:
  - PC=0x7FF with NEXT wraps to 0x000.
  - stall=1 for 3 cycles with pc_op=JUMP holds PC, IR and stack unchanged.
  - reset asserted in the same cycle as CALL leaves PC=0 and stack count=0.

Source files
------------

// File: rtl/pic_fetch_unit.sv
// Fetch stage for the 14-bit-instruction core: PC, IR and hardware return stack.
// Drives the program ROM address and applies PC-control commands from execute.
module pic_fetch_unit #(
    parameter int                 ADDR_W      = 11,
    parameter int                 INSTR_W     = 14,
    parameter int                 STACK_DEPTH = 8,
    parameter logic [INSTR_W-1:0] NOP_WORD    = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr_out,
    input  logic [INSTR_W-1:0] rom_data_in,
    input  logic [2:0]         pc_op,
    input  logic [ADDR_W-1:0]  target,
    input  logic               stall,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               stack_overflow,
    output logic               stack_underflow
);

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_JUMP = 3'd1,
        OP_CALL = 3'd2,
        OP_RET  = 3'd3,
        OP_SKIP = 3'd4
    } pc_op_e;

    localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_ONE   = SP_W'(1);
    localparam logic [SP_W:0]   CNT_ONE  = (SP_W+1)'(1);
    localparam logic [SP_W:0]   CNT_FULL = (SP_W+1)'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               vld_q, vld_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [SP_W:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               push;
    logic [SP_W-1:0]    sp_dec;
    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

    assign sp_dec = sp_q - SP_ONE;

    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        vld_d = vld_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (!stall) begin
            // Every command except NEXT leaves a bubble in IR.
            pc_d  = pc_q + PC_ONE;
            ir_d  = NOP_WORD;
            vld_d = 1'b0;
            case (pc_op)
                OP_JUMP: pc_d = target;
                OP_CALL: begin
                    push = 1'b1;
                    pc_d = target;
                    sp_d = sp_q + SP_ONE;
                    if (cnt_q == CNT_FULL) ovf_d = 1'b1;
                    else cnt_d = cnt_q + CNT_ONE;
                end
                OP_RET: begin
                    pc_d = stack_mem[sp_dec];
                    sp_d = sp_dec;
                    if (cnt_q == '0) unf_d = 1'b1;
                    else cnt_d = cnt_q - CNT_ONE;
                end
                OP_SKIP: ;
                default: begin
                    ir_d  = rom_data_in;
                    vld_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            ir_q  <= NOP_WORD;
            vld_q <= 1'b0;
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            vld_q <= vld_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents need no reset; only the pointer and count do.
    always_ff @(posedge clk) begin
        if (!reset && push) stack_mem[sp_q] <= pc_q;
    end

    assign rom_addr_out    = pc_q;
    assign pc_out          = pc_q;
    assign ir_out          = ir_q;
    assign ir_valid        = vld_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule
